// File: rtl/bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : bcd_pkg                                                      |
// | Description : Shared types, constants and helpers for the scanning         |
// |               binary-to-BCD converter (bcd_scan_conv, bcd_dabble_step).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bcd_pkg;

  typedef logic [3:0] digit_t;

  // Display code that the 7-segment driver renders as an unlit digit.
  localparam digit_t BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Number of decimal digits needed to hold any W-bit binary value.
  // (W*3)/10 + 1 undershoots log10(2) only slightly and is exact for W <= 32.
  function automatic int bcd_int_digits(input int w);
    return (w * 3) / 10 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dabble_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_dabble_step                                              |
// | Description : One combinational double-dabble iteration: every BCD digit   |
// |               >= 5 gets +3, then {bcd,bin} is shifted left by one bit.     |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : i_bcd [DI*4] - BCD accumulator before the step               |
// |               i_bin [W]    - remaining binary bits (MSB shifts in next)    |
// |               o_bcd [DI*4] - BCD accumulator after the step                |
// |               o_bin [W]    - binary bits after the shift                   |
// +----------------------------------------------------------------------------+
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int DI = 4,
  parameter int W  = 12
) (
  input  logic [DI*4-1:0] i_bcd,
  input  logic [W-1:0]    i_bin,
  output logic [DI*4-1:0] o_bcd,
  output logic [W-1:0]    o_bin
);

  logic [DI*4-1:0] w_adj;

  for (genvar k = 0; k < DI; k++) begin : g_digit
    digit_t w_d;
    assign w_d = i_bcd[k*4 +: 4];
    // Pre-correct so that the following doubling carries into the next digit.
    assign w_adj[k*4 +: 4] = (w_d >= 4'd5) ? w_d + 4'd3 : w_d;
  end

  assign o_bcd = {w_adj[DI*4-2:0], i_bin[W-1]};
  assign o_bin = {i_bin[W-2:0], 1'b0};

endmodule
`default_nettype wire

// File: rtl/bcd_scan_conv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_scan_conv                                                |
// | Description : Round-robin multi-channel binary-to-BCD converter with       |
// |               overflow saturation, optional leading-zero blanking and      |
// |               per-channel result registers for a 7-segment driver.         |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : clk   - clock, rising edge                                   |
// |               rst_n - asynchronous active-low reset                        |
// |               run   - enable scanning (sampled in IDLE only)               |
// |               vin   - N*W binary inputs, channel c at [c*W +: W]           |
// |               bcd   - N*D*4 results, channel c digit k at [(c*D+k)*4 +: 4] |
// |               upd   - N one-cycle pulses, channel result rewritten         |
// |               ovf   - N flags, last conversion exceeded 10^D-1             |
// |               busy  - conversion in progress (SHIFT or COMMIT)             |
// +----------------------------------------------------------------------------+
module bcd_scan_conv
  import bcd_pkg::*;
#(
  parameter int W     = 12,
  parameter int D     = 4,
  parameter int N     = 2,
  parameter bit BLANK = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [N*W-1:0]   vin,
  output logic [N*D*4-1:0] bcd,
  output logic [N-1:0]     upd,
  output logic [N-1:0]     ovf,
  output logic             busy
);

  localparam int c_DI   = bcd_int_digits(W);
  // Padded digit count so saturation and extraction work whether D is
  // smaller or larger than the internal digit count.
  localparam int c_DP   = (D > c_DI) ? D : c_DI;
  localparam int c_CHW  = (N > 1) ? $clog2(N) : 1;
  localparam int c_CNTW = 6;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CHW-1:0]   r_ch;
  logic [W-1:0]       r_bin;
  logic [W-1:0]       w_bin_step;
  logic [W-1:0]       w_vin_sel;
  logic [c_DI*4-1:0]  r_acc;
  logic [c_DI*4-1:0]  w_acc_step;
  logic [c_CNTW-1:0]  r_cnt;
  logic [N*D*4-1:0]   r_bcd;
  logic [N-1:0]       r_upd;
  logic [N-1:0]       r_ovf;
  logic [c_DP*4-1:0]  w_pad;
  logic [D*4-1:0]     w_res;
  logic               w_sat;
  logic               w_lead;

  bcd_dabble_step #(
    .DI (c_DI),
    .W  (W)
  ) u_step (
    .i_bcd (r_acc),
    .i_bin (r_bin),
    .o_bcd (w_acc_step),
    .o_bin (w_bin_step)
  );

  // Input channel mux.
  always_comb begin
    w_vin_sel = '0;
    for (int c = 0; c < N; c++) begin
      if (r_ch == c_CHW'(c)) w_vin_sel = vin[c*W +: W];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (run) w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == c_CNTW'(1)) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Conversion datapath and channel pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch  <= '0;
      r_bin <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (run) begin
            r_bin <= w_vin_sel;
            r_acc <= '0;
            r_cnt <= c_CNTW'(W);
          end
        end
        SHIFT: begin
          r_bin <= w_bin_step;
          r_acc <= w_acc_step;
          r_cnt <= r_cnt - c_CNTW'(1);
        end
        COMMIT: begin
          r_ch <= (r_ch == c_CHW'(N - 1)) ? '0 : r_ch + c_CHW'(1);
        end
        default: ;
      endcase
    end
  end

  // Saturation and blanking of the finished accumulator.
  always_comb begin
    w_pad              = '0;
    w_pad[c_DI*4-1:0]  = r_acc;
    w_sat              = 1'b0;
    w_lead             = 1'b1;
    for (int k = D; k < c_DP; k++) begin
      if (w_pad[k*4 +: 4] != 4'd0) w_sat = 1'b1;
    end
    w_res = w_pad[D*4-1:0];
    if (w_sat) begin
      w_res = {D{4'h9}};
    end else if (BLANK) begin
      // Walk down from the top digit; units digit is always shown.
      for (int k = D - 1; k >= 1; k--) begin
        if (w_res[k*4 +: 4] != 4'd0) w_lead = 1'b0;
        if (w_lead) w_res[k*4 +: 4] = BLANK_CODE;
      end
    end
  end

  // Output registers: only the committing channel is rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd <= '0;
      r_upd <= '0;
      r_ovf <= '0;
    end else begin
      r_upd <= '0;
      if (r_state == COMMIT) begin
        for (int c = 0; c < N; c++) begin
          if (r_ch == c_CHW'(c)) begin
            r_bcd[c*D*4 +: D*4] <= w_res;
            r_ovf[c]            <= w_sat;
            r_upd[c]            <= 1'b1;
          end
        end
      end
    end
  end

  assign bcd  = r_bcd;
  assign upd  = r_upd;
  assign ovf  = r_ovf;
  assign busy = (r_state == SHIFT) || (r_state == COMMIT);

endmodule
`default_nettype wire
